// File: rtl/recirc_param.sv
// recirc_param: multi-lane main/recirculation router with debounced route select and saturating recirc counter
module recirc_param #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 2,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic                   clk_2f,
  input  logic                   reset_L,
  input  logic                   active,
  input  logic [LANES-1:0]       valid_in,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   clr_cnt,
  output logic [LANES-1:0]       valid_main,
  output logic [LANES*WIDTH-1:0] data_main,
  output logic [LANES-1:0]       valid_recirc,
  output logic [LANES*WIDTH-1:0] data_recirc,
  output logic                   route,
  output logic                   switching,
  output logic [CNT_W-1:0]       recirc_cnt
);
  // state[1] is the route itself, so route comes straight off a flop
  typedef enum logic [1:0] {
    RECIRC      = 2'b00,
    PEND_MAIN   = 2'b01,
    MAIN        = 2'b10,
    PEND_RECIRC = 2'b11
  } state_t;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = CNT_W + PW + 1;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  localparam logic [SW-1:0] MAXC = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  state_t        state;
  logic [3:0]    stab;
  logic [PW-1:0] pop;
  logic [SW-1:0] sum;
  logic          differ;
  logic          flip;
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(valid_in[i]);
  end
  assign route  = state[1];
  assign differ = active != route;
  assign flip   = differ && (stab == LAST);
  assign sum    = SW'(recirc_cnt) + SW'(pop);
  always_ff @(posedge clk_2f or negedge reset_L)
    if (!reset_L) begin
      state        <= RECIRC;
      stab         <= '0;
      switching    <= 1'b0;
      valid_main   <= '0;
      data_main    <= '0;
      valid_recirc <= '0;
      data_recirc  <= '0;
      recirc_cnt   <= '0;
    end else begin
      state        <= !differ ? (route ? MAIN : RECIRC) :
                      flip    ? (active ? MAIN : RECIRC) :
                                (active ? PEND_MAIN : PEND_RECIRC);
      stab         <= (differ && !flip) ? stab + 4'd1 : 4'd0;
      switching    <= differ && !flip;
      valid_main   <= route ? valid_in : '0;
      data_main    <= route ? data_in : '0;
      valid_recirc <= route ? '0 : valid_in;
      data_recirc  <= route ? '0 : data_in;
      recirc_cnt   <= clr_cnt ? '0 :
                      route   ? recirc_cnt :
                      (sum > MAXC) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_recirc_param.sv
// tb_recirc_param: directed and randomized checks of two recirc_param instances against a behavioural model
module tb_recirc_param;
  logic        clk_2f = 1'b0;
  logic        reset_L;
  logic        active;
  logic [1:0]  valid_in;
  logic [63:0] data_in;
  logic        clr_cnt;
  logic [1:0]  vm[2];
  logic [1:0]  vr[2];
  logic [63:0] dm[2];
  logic [63:0] dr[2];
  logic        rt[2];
  logic        sw[2];
  logic [3:0]  cnt_a;
  logic [7:0]  cnt_b;
  logic [7:0]  cnt[2];
  int n_cmp = 0;
  int n_err = 0;
  int m_route[2];
  int m_run[2];
  int m_cnt[2];
  logic [1:0]  e_vm[2];
  logic [1:0]  e_vr[2];
  logic [63:0] e_dm[2];
  logic [63:0] e_dr[2];

  always #5 clk_2f = ~clk_2f;
  assign cnt[0] = {4'b0, cnt_a};
  assign cnt[1] = cnt_b;

  // instance a: SETTLE=2, CNT_W=4; instance b: SETTLE=3, CNT_W=8
  recirc_param #(.WIDTH(32), .LANES(2), .SETTLE(2), .CNT_W(4)) dut_a (
    .clk_2f(clk_2f), .reset_L(reset_L), .active(active), .valid_in(valid_in),
    .data_in(data_in), .clr_cnt(clr_cnt), .valid_main(vm[0]), .data_main(dm[0]),
    .valid_recirc(vr[0]), .data_recirc(dr[0]), .route(rt[0]), .switching(sw[0]),
    .recirc_cnt(cnt_a));
  recirc_param #(.WIDTH(32), .LANES(2), .SETTLE(3), .CNT_W(8)) dut_b (
    .clk_2f(clk_2f), .reset_L(reset_L), .active(active), .valid_in(valid_in),
    .data_in(data_in), .clr_cnt(clr_cnt), .valid_main(vm[1]), .data_main(dm[1]),
    .valid_recirc(vr[1]), .data_recirc(dr[1]), .route(rt[1]), .switching(sw[1]),
    .recirc_cnt(cnt_b));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_route[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
      e_vm[k] = '0; e_vr[k] = '0; e_dm[k] = '0; e_dr[k] = '0;
    end
  endtask

  // route rule: flip once active has disagreed with the route for `settle` consecutive edges
  task automatic model_edge();
    int pc;
    int settle;
    int maxc;
    pc = int'(valid_in[0]) + int'(valid_in[1]);
    for (int k = 0; k < 2; k++) begin
      settle = (k == 0) ? 2 : 3;
      maxc = (k == 0) ? 15 : 255;
      e_vm[k] = (m_route[k] == 1) ? valid_in : 2'b0;
      e_dm[k] = (m_route[k] == 1) ? data_in : 64'b0;
      e_vr[k] = (m_route[k] == 0) ? valid_in : 2'b0;
      e_dr[k] = (m_route[k] == 0) ? data_in : 64'b0;
      if (clr_cnt) m_cnt[k] = 0;
      else if (m_route[k] == 0) m_cnt[k] = (m_cnt[k] + pc > maxc) ? maxc : m_cnt[k] + pc;
      if (int'(active) == m_route[k]) m_run[k] = 0;
      else if (m_run[k] + 1 >= settle) begin
        m_route[k] = int'(active);
        m_run[k] = 0;
      end else m_run[k] = m_run[k] + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input string tag);
    reset_L = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({vm[k], vr[k], dm[k], dr[k], rt[k], sw[k], cnt[k]} !== '0) begin
        n_err++;
        $display("FAIL %s[%0d]: outputs vm=%b vr=%b dm=%h dr=%h route=%b sw=%b cnt=%0d, want all zero",
                 tag, k, vm[k], vr[k], dm[k], dr[k], rt[k], sw[k], cnt[k]);
      end
    end
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    active = 0; valid_in = 0; data_in = 0; clr_cnt = 0;
    apply_reset("reset");
  endtask

  task automatic test_recirc_passthrough();
    valid_in = 2'b11;
    data_in = {32'hFFEEEEEE, 32'hFFFFEEEE};
    tick();
    n_cmp++;
    if (vr[0] !== 2'b11 || dr[0] !== 64'hFFEEEEEE_FFFFEEEE) begin
      n_err++; $display("FAIL pass_recirc: got %b/%h want 11/ffeeeeeeffffeeee", vr[0], dr[0]);
    end
    n_cmp++;
    if (vm[0] !== 2'b00 || dm[0] !== 64'b0) begin
      n_err++; $display("FAIL pass_main_zero: got %b/%h want 00/0", vm[0], dm[0]);
    end
    n_cmp++;
    if (cnt[0] !== 8'd2) begin n_err++; $display("FAIL pass_cnt: got %0d want 2", cnt[0]); end
  endtask

  task automatic test_switch_main();
    logic [63:0] d;
    active = 1;
    valid_in = 2'b11;
    d = {$urandom, $urandom};
    data_in = d;
    tick();
    n_cmp++;
    if (sw[0] !== 1'b1 || rt[0] !== 1'b0) begin
      n_err++; $display("FAIL sw_edge0: sw=%b route=%b want 1/0", sw[0], rt[0]);
    end
    n_cmp++;
    if (vr[0] !== 2'b11 || dr[0] !== d || vm[0] !== 2'b00) begin
      n_err++; $display("FAIL sw_edge0_data: vr=%b dr=%h vm=%b want 11/%h/00", vr[0], dr[0], vm[0], d);
    end
    d = {$urandom, $urandom};
    data_in = d;
    tick();
    n_cmp++;
    if (sw[0] !== 1'b0 || rt[0] !== 1'b1) begin
      n_err++; $display("FAIL sw_edge1: sw=%b route=%b want 0/1", sw[0], rt[0]);
    end
    n_cmp++;
    if (vr[0] !== 2'b11 || dr[0] !== d || cnt[0] !== 8'd6) begin
      n_err++; $display("FAIL sw_edge1_data: vr=%b dr=%h cnt=%0d want 11/%h/6", vr[0], dr[0], cnt[0], d);
    end
    valid_in = 2'b01;
    d = {$urandom, $urandom};
    data_in = d;
    tick();
    n_cmp++;
    if (vm[0] !== 2'b01 || dm[0] !== d || vr[0] !== 2'b00 || dr[0] !== 64'b0) begin
      n_err++; $display("FAIL sw_edge2: vm=%b dm=%h vr=%b dr=%h want 01/%h/00/0", vm[0], dm[0], vr[0], dr[0], d);
    end
    n_cmp++;
    if (cnt[0] !== 8'd6) begin n_err++; $display("FAIL sw_cnt_frozen: got %0d want 6", cnt[0]); end
  endtask

  task automatic test_partial_main();
    valid_in = 2'b10;
    data_in = {32'hAAAA1234, 32'h12345678};
    tick();
    n_cmp++;
    if (vm[0] !== 2'b10 || dm[0] !== 64'hAAAA1234_12345678) begin
      n_err++; $display("FAIL partial_main: got %b/%h want 10/aaaa123412345678", vm[0], dm[0]);
    end
    n_cmp++;
    if (vr[0] !== 2'b00 || dr[0] !== 64'b0) begin
      n_err++; $display("FAIL partial_recirc_zero: got %b/%h want 00/0", vr[0], dr[0]);
    end
  endtask

  task automatic test_glitch();
    active = 0;
    valid_in = 2'b11;
    repeat (3) tick();
    active = 1;
    data_in = {$urandom, $urandom};
    tick();
    n_cmp++;
    if (sw[0] !== 1'b1 || rt[0] !== 1'b0 || vr[0] !== 2'b11 || dr[0] !== data_in) begin
      n_err++; $display("FAIL glitch_hi: sw=%b route=%b vr=%b dr=%h want 1/0/11/%h", sw[0], rt[0], vr[0], dr[0], data_in);
    end
    active = 0;
    data_in = {$urandom, $urandom};
    tick();
    n_cmp++;
    if (sw[0] !== 1'b0 || rt[0] !== 1'b0 || vr[0] !== 2'b11 || dr[0] !== data_in || vm[0] !== 2'b00) begin
      n_err++; $display("FAIL glitch_lo: sw=%b route=%b vr=%b dr=%h vm=%b want 0/0/11/%h/00", sw[0], rt[0], vr[0], dr[0], vm[0], data_in);
    end
    tick();
    n_cmp++;
    if (sw[0] !== 1'b0 || rt[0] !== 1'b0) begin
      n_err++; $display("FAIL glitch_after: sw=%b route=%b want 0/0", sw[0], rt[0]);
    end
  endtask

  task automatic test_saturation();
    clr_cnt = 1; valid_in = 2'b00;
    tick();
    n_cmp++;
    if (cnt[0] !== 8'd0) begin n_err++; $display("FAIL sat_clr0: got %0d want 0", cnt[0]); end
    clr_cnt = 0; valid_in = 2'b11;
    repeat (10) tick();
    n_cmp++;
    if (cnt[0] !== 8'd15) begin n_err++; $display("FAIL sat_hold: got %0d want 15", cnt[0]); end
    n_cmp++;
    if (cnt[1] !== 8'(m_cnt[1])) begin n_err++; $display("FAIL sat_wide: got %0d want %0d", cnt[1], m_cnt[1]); end
    clr_cnt = 1;
    tick();
    n_cmp++;
    if (cnt[0] !== 8'd0) begin n_err++; $display("FAIL sat_clr_wins: got %0d want 0", cnt[0]); end
    clr_cnt = 0;
  endtask

  task automatic test_async_mid_switch();
    active = 0;
    repeat (3) tick();
    active = 1;
    repeat (2) tick();
    n_cmp++;
    if (sw[1] !== 1'b1 || rt[1] !== 1'b0) begin
      n_err++; $display("FAIL async_pend: sw=%b route=%b want 1/0", sw[1], rt[1]);
    end
    apply_reset("async_reset");
    repeat (2) tick();
    n_cmp++;
    if (rt[1] !== 1'b0 || rt[0] !== 1'b1) begin
      n_err++; $display("FAIL async_after2: route_b=%b route_a=%b want 0/1", rt[1], rt[0]);
    end
    tick();
    n_cmp++;
    if (rt[1] !== 1'b1) begin n_err++; $display("FAIL async_after3: route_b=%b want 1", rt[1]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) active = ~active;
      valid_in = 2'($urandom);
      data_in = {$urandom, $urandom};
      clr_cnt = ($urandom_range(0, 15) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (vm[k] !== e_vm[k] || vr[k] !== e_vr[k]) begin
          n_err++; $display("FAIL rand_valid[%0d] cyc %0d: got %b/%b want %b/%b", k, c, vm[k], vr[k], e_vm[k], e_vr[k]);
        end
        n_cmp++;
        if (dm[k] !== e_dm[k] || dr[k] !== e_dr[k]) begin
          n_err++; $display("FAIL rand_data[%0d] cyc %0d: got %h/%h want %h/%h", k, c, dm[k], dr[k], e_dm[k], e_dr[k]);
        end
        n_cmp++;
        if (rt[k] !== 1'(m_route[k]) || sw[k] !== (m_run[k] != 0)) begin
          n_err++; $display("FAIL rand_route[%0d] cyc %0d: got %b/%b want %0d/%0d", k, c, rt[k], sw[k], m_route[k], m_run[k] != 0);
        end
        n_cmp++;
        if (cnt[k] !== 8'(m_cnt[k])) begin
          n_err++; $display("FAIL rand_cnt[%0d] cyc %0d: got %0d want %0d", k, c, cnt[k], m_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    reset_L = 1; active = 0; valid_in = 0; data_in = 0; clr_cnt = 0;
    #1;
    test_reset();
    test_recirc_passthrough();
    test_switch_main();
    test_partial_main();
    test_glitch();
    test_saturation();
    test_async_mid_switch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/recirc_param.md
Name: recirc_param

Overview:
Parametrised multi-lane recirculation router for the PCI physical-layer datapath. It is the next generation of the single-lane active/valid recirculation block. Each lane's word goes either to the recirculation (loopback/probe) path or to the main path, selected by a debounced `active` level. Adds lane count, width, a settle filter on `active`, registered outputs and a saturating recirculated-word counter.

Parameters:
WIDTH, 32, bits per lane word
LANES, 2, number of parallel lanes
SETTLE, 2, consecutive cycles `active` must differ from current route before route flips (legal range 1..15)
CNT_W, 8, width of recirculated-word counter

Ports:
clk_2f  input  1  sole clock, rising edge
reset_L  input  1  asynchronous, active-low reset
active  input  1  requested route: 1 = main, 0 = recirculate
valid_in  input  LANES  per-lane valid
data_in  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
clr_cnt  input  1  synchronous clear of recirc_cnt
valid_main  output  LANES  registered valid on main path
data_main  output  LANES*WIDTH  registered data on main path
valid_recirc  output  LANES  registered valid on recirc path
data_recirc  output  LANES*WIDTH  registered data on recirc path
route  output  1  current route register (0 = RECIRC, 1 = MAIN)
switching  output  1  high while a route change is pending
recirc_cnt  output  CNT_W  saturating count of valid words sent to recirc path

Behaviour:
- Reset (reset_L = 0, asynchronous): all outputs and internal state go to 0 immediately. route = 0, i.e. state RECIRC.
- Reset takes effect mid-operation, including during a pending switch. The first edge after release behaves as if coming from RECIRC with the settle counter at 0.
- FSM states: RECIRC, PEND_MAIN, MAIN, PEND_RECIRC. Internal settle counter `stab` (4 bits).
- Per rising edge, with `active` sampled:
  - If active == route: stab <= 0. A pending state returns to its base state (PEND_MAIN -> RECIRC, PEND_RECIRC -> MAIN).
  - If active != route and stab == SETTLE-1: route <= active, stab <= 0. The state becomes MAIN or RECIRC accordingly.
  - Otherwise: stab <= stab+1 and the state becomes PEND_MAIN or PEND_RECIRC.
- switching = (stab != 0), registered.
- With SETTLE = 1 there is no pending state: route follows active with one cycle of latency.
- Routing latency is 1 cycle. Data sampled at edge t is steered by the value of route *before* edge t, so words accepted in the edge that flips route still use the old path.
- Selected path: valid_x[i] <= valid_in[i] and data_x lane i <= data_in lane i. Data is registered regardless of valid.
- Unselected path: valid <= 0 and data <= 0 on every lane, the same cycle.
- recirc_cnt is updated each edge:
  - If clr_cnt = 1: recirc_cnt <= 0. Clear wins over a simultaneous increment.
  - Else, if route = 0: add popcount(valid_in) and saturate at 2^CNT_W - 1. There is no wrap-around.
  - Else: hold.
- Lanes are independent. A partial valid mask is passed through bit-exact.
- No backpressure: every edge accepts the input.

Test Plan:
1. Recirc passthrough (LANES=2, WIDTH=32). route=0, active=0, valid_in=2'b11, data_in={32'hFFEEEEEE, 32'hFFFFEEEE}. Next cycle: valid_recirc=2'b11, data_recirc equal to data_in, valid_main=0, data_main=0, recirc_cnt=2.
2. Switch to main (SETTLE=2). active rises and is held from edge0.
   - After edge0: switching=1, route=0, and the word sampled at edge0 is on recirc.
   - After edge1: route=1 and switching=0; the word sampled at edge1 is still on recirc.
   - From the word sampled at edge2 onward: valid_main follows valid_in, valid_recirc=0, recirc_cnt frozen.
3. Glitch filter (SETTLE=2). active=1 for a single cycle, then 0. switching pulses high for exactly one cycle, route stays 0, and all data remains on recirc.
4. Partial valid in MAIN. valid_in=2'b10 with lane1=32'hAAAA1234 and lane0=32'h12345678. Next cycle: valid_main=2'b10, data_main={32'hAAAA1234, 32'h12345678}, recirc outputs 0.
5. Counter saturation (CNT_W=4). 10 cycles of route=0 with valid_in=2'b11 gives recirc_cnt=15 (no wrap). Then clr_cnt=1 together with valid_in=2'b11 gives recirc_cnt=0.
6. Async reset mid-switch (SETTLE=3, in PEND_MAIN with stab=2). Dropping reset_L between edges zeroes all outputs immediately. After release with active=1, route becomes 1 only after 3 further edges.
